// File: rtl/mmu_result_drain.sv
// mmu_result_drain: receive side of the MMU result interface.
// Each 8-lane x 32-bit row strobed by row_valid is captured into a DEPTH-row
// FIFO and streamed out one 32-bit word per accept, lane 0 first.
// Rows arriving while the FIFO is full (and no pop that cycle) are dropped
// and the sticky overflow flag is raised.
// Optional feature: define MMU_DRAIN_RELU_EN to clamp negative lanes to zero
// on m_data (stored rows stay raw).
module mmu_result_drain #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     row_valid,
    input  logic [31:0]              row_data_0,
    input  logic [31:0]              row_data_1,
    input  logic [31:0]              row_data_2,
    input  logic [31:0]              row_data_3,
    input  logic [31:0]              row_data_4,
    input  logic [31:0]              row_data_5,
    input  logic [31:0]              row_data_6,
    input  logic [31:0]              row_data_7,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [31:0]              m_data,
    output logic                     m_last,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   rows_pending,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef logic [7:0][31:0] row_t;
    typedef enum logic {S_EMPTY = 1'b0, S_STREAM = 1'b1} state_t;

    row_t            mem_q [DEPTH];
    row_t            row_in;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      lane_q, lane_d;
    logic [AW:0]     count_q, count_d;
    logic            overflow_q, overflow_d;
    state_t          state_q, state_d;

    logic            accept, pop, push;
    logic [31:0]     lane_word;

    assign row_in = {row_data_7, row_data_6, row_data_5, row_data_4,
                     row_data_3, row_data_2, row_data_1, row_data_0};

    assign accept = m_valid && m_ready;
    assign pop    = accept && (lane_q == 3'd7);
    // A pop in the same cycle frees the slot, so a full FIFO still takes the row.
    assign push   = row_valid && ((count_q != DEPTH_C) || pop);

    // Next-state: clear wins over every other event, including a concurrent row.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        lane_d     = lane_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        state_d    = state_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            lane_d     = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            state_d    = S_EMPTY;
        end else begin
            if (accept) lane_d = lane_q + 3'd1;   // 7 wraps to 0 on pop
            if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;
            if (push)   wr_ptr_d = wr_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (!push && pop) count_d = count_q - 1'b1;
            if (row_valid && !push) overflow_d = 1'b1;
            state_d = (count_d != '0) ? S_STREAM : S_EMPTY;
        end
    end

    // Control state and FSM register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            lane_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            state_q    <= S_EMPTY;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            lane_q     <= lane_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    // Row storage: not reset; only written on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !clear) mem_q[wr_ptr_q] <= row_in;
    end

    assign lane_word = mem_q[rd_ptr_q][lane_q];

    // Output mux; gated by m_valid so the unreset array never shows on the bus.
    always_comb begin
        m_data = '0;
        if (m_valid) begin
`ifdef MMU_DRAIN_RELU_EN
            m_data = lane_word[31] ? 32'h0000_0000 : lane_word;
`else
            m_data = lane_word;
`endif
        end
    end

    assign m_valid      = (state_q == S_STREAM);
    assign m_last       = m_valid && (lane_q == 3'd7);
    assign full         = (count_q == DEPTH_C);
    assign rows_pending = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_mmu_result_drain.sv
// Directed bench for mmu_result_drain (DEPTH=4) with a word scoreboard.
module tb_mmu_result_drain;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear = 1'b0;
    logic        row_valid = 1'b0;
    logic [31:0] row_buf [8];
    logic        m_valid, m_ready, m_last, full, overflow;
    logic [31:0] m_data;
    logic [2:0]  rows_pending;

    typedef struct packed { logic [31:0] d; logic l; } exp_t;
    exp_t q[$];

    int checks = 0;
    int failures = 0;
    int acc_cnt = 0;

    always #5 clk = ~clk;

    mmu_result_drain #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .row_valid(row_valid),
        .row_data_0(row_buf[0]), .row_data_1(row_buf[1]),
        .row_data_2(row_buf[2]), .row_data_3(row_buf[3]),
        .row_data_4(row_buf[4]), .row_data_5(row_buf[5]),
        .row_data_6(row_buf[6]), .row_data_7(row_buf[7]),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .m_last(m_last), .full(full), .rows_pending(rows_pending),
        .overflow(overflow)
    );

    function automatic logic [31:0] present(input logic [31:0] x);
`ifdef MMU_DRAIN_RELU_EN
        return x[31] ? 32'h0 : x;
`else
        return x;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_row(input logic [31:0] base);
        for (int i = 0; i < 8; i++) row_buf[i] = base + 32'(i);
    endtask

    // One cycle: score any word accepted at the coming edge, then step past it.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (m_valid === 1'b1 && m_ready === 1'b1) begin
            acc_cnt++;
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_word observed=%h expected=none", m_data);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("word_data", m_data, e.d);
                chk("word_last", 32'(m_last), 32'(e.l));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input bit accepted);
        exp_t e;
        row_valid = 1'b1;
        if (accepted)
            for (int i = 0; i < 8; i++) begin
                e.d = present(row_buf[i]);
                e.l = (i == 7);
                q.push_back(e);
            end
        tick();
        row_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && q.size() > 0; i++) tick();
        chk("drain_left", 32'(q.size()), 32'd0);
    endtask

    initial begin
        int a0;
        logic [31:0] hold;
        logic was_v, rdy;
        m_ready = 1'b0;
        set_row(32'h0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_m_last", 32'(m_last), 32'd0);
        chk("rst_m_data", m_data, 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_rows_pending", 32'(rows_pending), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single row, ready high: zero-bubble, 8 consecutive words
        m_ready = 1'b1;
        set_row(32'd1);
        strobe(1'b1);
        chk("lat_m_valid", 32'(m_valid), 32'd1);
        chk("lat_lane0", m_data, 32'd1);
        a0 = acc_cnt;
        for (int i = 0; i < 8; i++) begin
            chk("stream_valid", 32'(m_valid), 32'd1);
            tick();
        end
        chk("row1_accepts", 32'(acc_cnt - a0), 32'd8);
        chk("row1_idle_valid", 32'(m_valid), 32'd0);
        chk("row1_pending", 32'(rows_pending), 32'd0);

        // Ready toggled 1,0,0,1: stall stability, exactly 8 accepts
        set_row(32'h100);
        strobe(1'b1);
        a0 = acc_cnt;
        for (int k = 0; k < 64 && q.size() > 0; k++) begin
            rdy = ((k % 4) == 0) || ((k % 4) == 3);
            m_ready = rdy;
            hold = m_data;
            was_v = m_valid;
            tick();
            if (!rdy && was_v) chk("stall_stable", m_data, hold);
        end
        chk("toggle_accepts", 32'(acc_cnt - a0), 32'd8);
        chk("toggle_pending", 32'(rows_pending), 32'd0);

        // Fill to full, then push F together with A's last word
        m_ready = 1'b0;
        for (int r = 1; r <= 4; r++) begin
            set_row(32'(r) << 12);
            strobe(1'b1);
        end
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_pending", 32'(rows_pending), 32'd4);
        m_ready = 1'b1;
        repeat (7) tick();
        chk("a_last_flag", 32'(m_last), 32'd1);
        set_row(32'h6000);
        strobe(1'b1);
        chk("pushpop_pending", 32'(rows_pending), 32'd4);
        chk("pushpop_full", 32'(full), 32'd1);
        chk("pushpop_overflow", 32'(overflow), 32'd0);
        drain();
        chk("pushpop_empty", 32'(rows_pending), 32'd0);

        // Five strobes with the sink stalled: E dropped, overflow sticky
        m_ready = 1'b0;
        for (int r = 10; r <= 13; r++) begin
            set_row(32'(r) << 12);
            strobe(1'b1);
        end
        chk("ovf_full_after4", 32'(full), 32'd1);
        set_row(32'hE000);
        strobe(1'b0);
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_pending", 32'(rows_pending), 32'd4);
        m_ready = 1'b1;
        a0 = acc_cnt;
        drain();
        chk("ovf_words", 32'(acc_cnt - a0), 32'd32);
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Mid-row clear together with a row strobe
        set_row(32'h7000);
        strobe(1'b1);
        repeat (3) tick();
        m_ready = 1'b0;
        set_row(32'h7700);
        row_valid = 1'b1;
        clear = 1'b1;
        tick();
        row_valid = 1'b0;
        clear = 1'b0;
        q.delete();
        chk("clr_m_valid", 32'(m_valid), 32'd0);
        chk("clr_pending", 32'(rows_pending), 32'd0);
        chk("clr_overflow", 32'(overflow), 32'd0);
        chk("clr_m_last", 32'(m_last), 32'd0);

        // Following row streams from lane 0; lane 3 negative
        set_row(32'h8000);
        row_buf[3] = 32'hFFFF_FFF6;
        m_ready = 1'b1;
        strobe(1'b1);
        chk("post_clr_lane0", m_data, 32'h8000);
        drain();

        // Reset mid-stream: outputs drop at once
        set_row(32'h9000);
        strobe(1'b1);
        repeat (2) tick();
        rst_n = 1'b0;
        #1;
        q.delete();
        chk("mid_rst_valid", 32'(m_valid), 32'd0);
        chk("mid_rst_data", m_data, 32'd0);
        chk("mid_rst_pending", 32'(rows_pending), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        set_row(32'hA000);
        strobe(1'b1);
        drain();
        chk("final_idle", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
